// File: rtl/uctl_local_buf_mem.sv
// Local-buffer memory responder: write port (mem0) and read port (mem1) sharing one word array.
// Optional macro UCTL_LBUF_WR_BYPASS_EN forwards same-edge write data to a colliding read.
module uctl_local_buf_mem #(
    parameter int DATA_SIZE      = 32,
    parameter int ADDR_SIZE      = 32,
    parameter int MEM_DEPTH_LOG2 = 10,
    parameter int RD_WAIT        = 0
) (
    input  logic                 coreClk,
    input  logic                 coreRst_n,
    input  logic [ADDR_SIZE-1:0] mem0_addr,
    input  logic [DATA_SIZE-1:0] mem0_dataIn,
    input  logic                 mem0_wr,
    output logic                 mem0_ackOut,
    input  logic [ADDR_SIZE-1:0] mem1_addr,
    input  logic                 mem1_rd,
    output logic                 mem1_ackOut,
    output logic [DATA_SIZE-1:0] mem1_dataOut,
    output logic                 mem1_dataVld,
    output logic                 mem_oorErr
);

    localparam int DEPTH   = 1 << MEM_DEPTH_LOG2;
    localparam int IDX_MSB = MEM_DEPTH_LOG2 + 1;
    localparam logic [3:0] WAIT_LOAD = (RD_WAIT > 0) ? 4'(RD_WAIT - 1) : 4'd0;

    typedef enum logic {W_IDLE = 1'b0, W_ACK = 1'b1} w_state_t;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_ACK = 2'd2, R_VLD = 2'd3} r_state_t;

    logic [DATA_SIZE-1:0] mem_array [0:DEPTH-1];

    logic [MEM_DEPTH_LOG2-1:0] wr_idx;
    logic [MEM_DEPTH_LOG2-1:0] rd_addr_idx;
    logic                      wr_addr_oor;
    logic                      rd_addr_oor;
    logic                      unused_addr_bits;

    assign wr_idx           = mem0_addr[IDX_MSB:2];
    assign rd_addr_idx      = mem1_addr[IDX_MSB:2];
    assign wr_addr_oor      = |mem0_addr[ADDR_SIZE-1:IDX_MSB+1];
    assign rd_addr_oor      = |mem1_addr[ADDR_SIZE-1:IDX_MSB+1];
    assign unused_addr_bits = ^{mem0_addr[1:0], mem1_addr[1:0]};

    // ---------------- write FSM ----------------
    w_state_t w_state_reg;
    w_state_t w_state_next;
    logic     w_oor_reg;
    logic     w_oor_next;
    logic     wr_commit;

    always_ff @(posedge coreClk or negedge coreRst_n) begin
        if (!coreRst_n) begin
            w_state_reg <= W_IDLE;
            w_oor_reg   <= 1'b0;
        end else begin
            w_state_reg <= w_state_next;
            w_oor_reg   <= w_oor_next;
        end
    end

    always_comb begin
        w_state_next = w_state_reg;
        w_oor_next   = w_oor_reg;
        wr_commit    = 1'b0;
        case (w_state_reg)
            W_IDLE: begin
                if (mem0_wr) begin
                    w_state_next = W_ACK;
                    w_oor_next   = wr_addr_oor;
                    wr_commit    = !wr_addr_oor;
                end
            end
            W_ACK:   w_state_next = W_IDLE;
            default: w_state_next = W_IDLE;
        endcase
    end

    always_ff @(posedge coreClk) begin
        if (wr_commit) begin
            mem_array[wr_idx] <= mem0_dataIn;
        end
    end

    // ---------------- read FSM ----------------
    r_state_t                  r_state_reg;
    r_state_t                  r_state_next;
    logic [MEM_DEPTH_LOG2-1:0] r_idx_reg;
    logic [MEM_DEPTH_LOG2-1:0] r_idx_next;
    logic                      r_oor_reg;
    logic                      r_oor_next;
    logic [3:0]                r_cnt_reg;
    logic [3:0]                r_cnt_next;
    logic                      rd_sample;
    logic [MEM_DEPTH_LOG2-1:0] rd_sample_idx;
    logic [DATA_SIZE-1:0]      rd_data_reg;

    always_ff @(posedge coreClk or negedge coreRst_n) begin
        if (!coreRst_n) begin
            r_state_reg <= R_IDLE;
            r_idx_reg   <= '0;
            r_oor_reg   <= 1'b0;
            r_cnt_reg   <= 4'd0;
        end else begin
            r_state_reg <= r_state_next;
            r_idx_reg   <= r_idx_next;
            r_oor_reg   <= r_oor_next;
            r_cnt_reg   <= r_cnt_next;
        end
    end

    always_comb begin
        r_state_next = r_state_reg;
        r_idx_next   = r_idx_reg;
        r_oor_next   = r_oor_reg;
        r_cnt_next   = r_cnt_reg;
        case (r_state_reg)
            // A request seen in R_VLD chains straight into the next access.
            R_IDLE, R_VLD: begin
                if (mem1_rd) begin
                    r_idx_next   = rd_addr_idx;
                    r_oor_next   = rd_addr_oor;
                    r_cnt_next   = WAIT_LOAD;
                    r_state_next = (RD_WAIT == 0) ? R_ACK : R_WAIT;
                end else begin
                    r_state_next = R_IDLE;
                end
            end
            R_WAIT: begin
                if (r_cnt_reg == 4'd0) begin
                    r_state_next = R_ACK;
                end else begin
                    r_cnt_next = r_cnt_reg - 4'd1;
                end
            end
            R_ACK:   r_state_next = R_VLD;
            default: r_state_next = R_IDLE;
        endcase
    end

    // Array is sampled on the edge entering R_ACK; without a wait phase the index comes straight off the bus.
    assign rd_sample     = (r_state_next == R_ACK);
    assign rd_sample_idx = (r_state_reg == R_WAIT) ? r_idx_reg : rd_addr_idx;

    always_ff @(posedge coreClk) begin
        if (rd_sample) begin
`ifdef UCTL_LBUF_WR_BYPASS_EN
            if (wr_commit && (wr_idx == rd_sample_idx)) begin
                rd_data_reg <= mem0_dataIn;
            end else begin
                rd_data_reg <= mem_array[rd_sample_idx];
            end
`else
            rd_data_reg <= mem_array[rd_sample_idx];
`endif
        end
    end

    // ---------------- outputs ----------------
    assign mem0_ackOut  = (w_state_reg == W_ACK);
    assign mem1_ackOut  = (r_state_reg == R_ACK);
    assign mem1_dataVld = (r_state_reg == R_VLD);
    assign mem1_dataOut = (mem1_dataVld && !r_oor_reg) ? rd_data_reg : '0;
    assign mem_oorErr   = (mem0_ackOut && w_oor_reg) || (mem1_ackOut && r_oor_reg);

endmodule

// File: tb/tb_uctl_local_buf_mem.sv
// Bench for uctl_local_buf_mem: table-driven transactions on an RD_WAIT=0 instance with a read-data
// scoreboard, plus hand sequences (held write, collision, back-to-back reads, reset in R_WAIT on RD_WAIT=3).
module tb_uctl_local_buf_mem;

    logic        clk;
    logic        rst_n;
    logic        rst3_n;

    logic [31:0] a0w, d0w, a0r, q0r;
    logic        wr0, ack0w, rd0, ack0r, vld0, oor0;
    logic [31:0] a3w, d3w, a3r, q3r;
    logic        wr3, ack3w, rd3, ack3r, vld3, oor3;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

`ifdef UCTL_LBUF_WR_BYPASS_EN
    localparam logic [31:0] COLL_EXP = 32'h55AA55AA;
`else
    localparam logic [31:0] COLL_EXP = 32'h0;
`endif

    uctl_local_buf_mem #(.DATA_SIZE(32), .ADDR_SIZE(32), .MEM_DEPTH_LOG2(10), .RD_WAIT(0)) dut0 (
        .coreClk(clk), .coreRst_n(rst_n),
        .mem0_addr(a0w), .mem0_dataIn(d0w), .mem0_wr(wr0), .mem0_ackOut(ack0w),
        .mem1_addr(a0r), .mem1_rd(rd0), .mem1_ackOut(ack0r), .mem1_dataOut(q0r),
        .mem1_dataVld(vld0), .mem_oorErr(oor0)
    );

    uctl_local_buf_mem #(.DATA_SIZE(32), .ADDR_SIZE(32), .MEM_DEPTH_LOG2(10), .RD_WAIT(3)) dut3 (
        .coreClk(clk), .coreRst_n(rst3_n),
        .mem0_addr(a3w), .mem0_dataIn(d3w), .mem0_wr(wr3), .mem0_ackOut(ack3w),
        .mem1_addr(a3r), .mem1_rd(rd3), .mem1_ackOut(ack3r), .mem1_dataOut(q3r),
        .mem1_dataVld(vld3), .mem_oorErr(oor3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_rd;
        logic [31:0] addr;
        logic [31:0] data;   // write data, or expected read data
        bit          oor;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic wr0_op(input logic [31:0] addr, input logic [31:0] data, input bit exp_oor);
        @(negedge clk);
        a0w = addr; d0w = data; wr0 = 1'b1;
        @(posedge clk); #1;
        chk("wr_ack", 32'(ack0w), 32'd1);
        chk("wr_oor", 32'(oor0), 32'(exp_oor));
        @(negedge clk);
        wr0 = 1'b0;
        @(posedge clk); #1;
        chk("wr_ack_pulse", 32'(ack0w), 32'd0);
    endtask

    task automatic rd0_op(input logic [31:0] addr, input logic [31:0] exp_data, input bit exp_oor);
        @(negedge clk);
        a0r = addr; rd0 = 1'b1;
        exp_q.push_back(exp_data);
        @(posedge clk); #1;
        chk("rd_ack", 32'(ack0r), 32'd1);
        chk("rd_oor", 32'(oor0), 32'(exp_oor));
        @(negedge clk);
        rd0 = 1'b0;
        @(posedge clk); #1;
        chk("rd_vld", 32'(vld0), 32'd1);
        chk("rd_ack_pulse", 32'(ack0r), 32'd0);
    endtask

    // Scoreboard: every dataVld on the RD_WAIT=0 instance pops one expected word.
    always begin
        @(posedge clk); #1;
        if (vld0 === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rd_unexpected_vld: got data 0x%0h required no dataVld", q0r);
            end else begin
                chk("rd_data", q0r, exp_q.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] h_addr [4];
        logic [31:0] h_data [4];
        logic        a;
        logic        seen;
        int          k;

        vecs[0]  = '{1'b0, 32'h0000_0010, 32'hDEADBEEF, 1'b0};
        vecs[1]  = '{1'b1, 32'h0000_0010, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b0, 32'h0000_0013, 32'h12345678, 1'b0};
        vecs[3]  = '{1'b1, 32'h0000_0010, 32'h12345678, 1'b0};
        vecs[4]  = '{1'b0, 32'h0000_0FFC, 32'hA5A5A5A5, 1'b0};
        vecs[5]  = '{1'b1, 32'h0000_0FFC, 32'hA5A5A5A5, 1'b0};
        vecs[6]  = '{1'b1, 32'h0000_1000, 32'h0,        1'b1};
        vecs[7]  = '{1'b0, 32'h0000_1010, 32'h11111111, 1'b1};
        vecs[8]  = '{1'b1, 32'h0000_0010, 32'h12345678, 1'b0};
        vecs[9]  = '{1'b1, 32'h8000_0010, 32'h0,        1'b1};
        vecs[10] = '{1'b0, 32'h0000_0000, 32'hCAFEF00D, 1'b0};
        vecs[11] = '{1'b1, 32'h0000_0003, 32'hCAFEF00D, 1'b0};

        h_addr = '{32'h100, 32'h104, 32'h108, 32'h10C};
        h_data = '{32'h0A0A0001, 32'h0B0B0002, 32'h0C0C0003, 32'h0D0D0004};

        rst_n = 1'b0; rst3_n = 1'b0;
        a0w = '0; d0w = '0; wr0 = 1'b0; a0r = '0; rd0 = 1'b0;
        a3w = '0; d3w = '0; wr3 = 1'b0; a3r = '0; rd3 = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_ack", 32'(ack0w), 32'd0);
        chk("rst_rd_ack", 32'(ack0r), 32'd0);
        chk("rst_vld",    32'(vld0),  32'd0);
        chk("rst_data",   q0r,        32'd0);
        chk("rst_oor",    32'(oor0),  32'd0);
        chk("rst3_vld",   32'(vld3),  32'd0);
        @(negedge clk);
        rst_n = 1'b1; rst3_n = 1'b1;

        // Table-driven transactions
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].is_rd) rd0_op(vecs[i].addr, vecs[i].data, vecs[i].oor);
            else               wr0_op(vecs[i].addr, vecs[i].data, vecs[i].oor);
        end

        // mem0_wr held high over four addresses: one ack every two cycles
        @(negedge clk);
        a0w = h_addr[0]; d0w = h_data[0]; wr0 = 1'b1;
        k = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            a = ack0w;
            chk("hold_ack", 32'(a), 32'((c % 2) == 0));
            @(negedge clk);
            if (a) begin
                k++;
                if (k < 4) begin
                    a0w = h_addr[k]; d0w = h_data[k];
                end else begin
                    wr0 = 1'b0;
                end
            end
        end
        for (int i = 0; i < 4; i++) rd0_op(h_addr[i], h_data[i], 1'b0);

        // Write/read collision at 0x20
        wr0_op(32'h20, 32'h0, 1'b0);
        @(negedge clk);
        a0w = 32'h20; d0w = 32'h55AA55AA; wr0 = 1'b1;
        a0r = 32'h20; rd0 = 1'b1;
        exp_q.push_back(COLL_EXP);
        @(posedge clk); #1;
        chk("coll_wr_ack", 32'(ack0w), 32'd1);
        chk("coll_rd_ack", 32'(ack0r), 32'd1);
        @(negedge clk);
        wr0 = 1'b0; rd0 = 1'b0;
        @(posedge clk); #1;
        chk("coll_vld", 32'(vld0), 32'd1);
        rd0_op(32'h20, 32'h55AA55AA, 1'b0);

        // Out-of-range on both ports at once: one single-cycle error pulse
        @(negedge clk);
        a0w = 32'h2000; d0w = 32'hFFFFFFFF; wr0 = 1'b1;
        a0r = 32'h1000; rd0 = 1'b1;
        exp_q.push_back(32'h0);
        @(posedge clk); #1;
        chk("dual_oor_pulse", 32'(oor0), 32'd1);
        @(negedge clk);
        wr0 = 1'b0; rd0 = 1'b0;
        @(posedge clk); #1;
        chk("dual_oor_single", 32'(oor0), 32'd0);
        rd0_op(32'h0, 32'hCAFEF00D, 1'b0);

        // Back-to-back reads with mem1_rd held through R_VLD
        @(negedge clk);
        a0r = 32'h10; rd0 = 1'b1;
        exp_q.push_back(32'h12345678);
        @(posedge clk); #1;
        chk("b2b_ack1", 32'(ack0r), 32'd1);
        @(negedge clk);
        a0r = 32'h20;
        exp_q.push_back(32'h55AA55AA);
        @(posedge clk); #1;
        chk("b2b_vld1",  32'(vld0),  32'd1);
        chk("b2b_noack", 32'(ack0r), 32'd0);
        @(posedge clk); #1;
        chk("b2b_ack2", 32'(ack0r), 32'd1);
        @(negedge clk);
        rd0 = 1'b0;
        @(posedge clk); #1;
        chk("b2b_vld2", 32'(vld0), 32'd1);
        @(posedge clk); #1;
        chk("b2b_idle", 32'({ack0r, vld0}), 32'd0);

        // RD_WAIT=3 instance: reset pulsed while in R_WAIT
        @(negedge clk);
        a3w = 32'h20; d3w = 32'h13572468; wr3 = 1'b1;
        @(posedge clk); #1;
        chk("d3_wr_ack", 32'(ack3w), 32'd1);
        @(negedge clk);
        wr3 = 1'b0;
        @(negedge clk);
        a3r = 32'h20; rd3 = 1'b1;
        @(posedge clk); #1;
        chk("d3_wait_noack1", 32'(ack3r), 32'd0);
        @(posedge clk); #1;
        chk("d3_wait_noack2", 32'(ack3r), 32'd0);
        @(negedge clk);
        rst3_n = 1'b0;
        #1;
        chk("d3_rst_ack",  32'(ack3r), 32'd0);
        chk("d3_rst_vld",  32'(vld3),  32'd0);
        chk("d3_rst_data", q3r,        32'd0);
        chk("d3_rst_oor",  32'(oor3),  32'd0);
        rd3 = 1'b0;
        repeat (2) @(negedge clk);
        rst3_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (ack3r || vld3) seen = 1'b1;
        end
        chk("d3_rst_dropped", 32'(seen), 32'd0);

        // RD_WAIT=3 latency: ack 4 cycles, dataVld 5 cycles after the rd sample
        @(negedge clk);
        rd3 = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            chk("d3_lat_ack", 32'(ack3r), 32'(c == 4));
            chk("d3_lat_vld", 32'(vld3),  32'(c == 5));
            if (c == 5) chk("d3_lat_data", q3r, 32'h13572468);
            @(negedge clk);
            if (c >= 4) rd3 = 1'b0;
        end

        repeat (3) @(posedge clk);
        #2;
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
